// File: rtl/fix_cfg_pkg.sv
// Shared types for the multi-session FIX configuration store: record layout,
// write FSM states and validation result codes.
package fix_cfg_pkg;

  localparam int COMP_ID_W = 256;

  typedef struct packed {
    logic [1:0]           connect_type;
    logic [7:0]           reconnect_int;
    logic [15:0]          start_time;
    logic [15:0]          end_time;
    logic [5:0]           begin_string;
    logic [5:0]           default_appl_ver_id;
    logic [COMP_ID_W-1:0] sender_comp_id;
    logic [COMP_ID_W-1:0] target_comp_id;
    logic [15:0]          host_addr;
    logic [7:0]           heartbeat_int;
  } fix_cfg_t;

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} cfg_state_e;

  localparam logic [2:0] CFG_OK         = 3'd0;
  localparam logic [2:0] CFG_ERR_SESS   = 3'd1;
  localparam logic [2:0] CFG_ERR_HB     = 3'd2;
  localparam logic [2:0] CFG_ERR_TIME   = 3'd3;
  localparam logic [2:0] CFG_ERR_CTYPE  = 3'd4;
  localparam logic [2:0] CFG_ERR_COMPID = 3'd5;

  localparam logic [1:0] CONNECT_TYPE_RSVD = 2'b11;

endpackage

// File: rtl/fix_cfg_check.sv
// Combinational record validator; returns the lowest-numbered failing rule,
// or CFG_OK. Shared with the logon path.
module fix_cfg_check
  import fix_cfg_pkg::*;
#(
  parameter  int NUM_SESS = 4,
  localparam int SESS_W   = $clog2(NUM_SESS)
) (
  input  fix_cfg_t        cfg,
  input  logic [SESS_W:0] sess,
  output logic [2:0]      errCode
);

  localparam logic [SESS_W:0] SESS_LIMIT = NUM_SESS[SESS_W:0];

  // start == end == 0 denotes a 24h session, not an empty window
  logic allDay;
  assign allDay = (cfg.start_time == '0) && (cfg.end_time == '0);

  logic unusedFields;
  assign unusedFields = ^{cfg.reconnect_int, cfg.begin_string,
                          cfg.default_appl_ver_id, cfg.host_addr};

  always_comb begin
    errCode = CFG_OK;
    if (sess >= SESS_LIMIT)
      errCode = CFG_ERR_SESS;
    else if (cfg.heartbeat_int == '0)
      errCode = CFG_ERR_HB;
    else if ((cfg.start_time >= cfg.end_time) && !allDay)
      errCode = CFG_ERR_TIME;
    else if (cfg.connect_type == CONNECT_TYPE_RSVD)
      errCode = CFG_ERR_CTYPE;
    else if (cfg.sender_comp_id == cfg.target_comp_id)
      errCode = CFG_ERR_COMPID;
  end

endmodule

// File: rtl/fix_session_config.sv
// Multi-session FIX configuration store: handshaked, validated writes into a
// NUM_SESS-entry table with per-session invalidate and a registered read port.
module fix_session_config
  import fix_cfg_pkg::*;
#(
  parameter  int NUM_SESS = 4,
  localparam int SESS_W   = $clog2(NUM_SESS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [SESS_W:0]     cfg_sess_i,
  input  fix_cfg_t            cfg_i,
  output logic                cfg_done_o,
  output logic [2:0]          cfg_err_code_o,
  input  logic                inv_i,
  input  logic [SESS_W-1:0]   inv_sess_i,
  input  logic [SESS_W:0]     rd_sess_i,
  output fix_cfg_t            rd_cfg_o,
  output logic                rd_valid_o,
  output logic [NUM_SESS-1:0] sess_valid_o
);

  // state  | meaning
  // IDLE   | ready for a write; capture record into staging on handshake
  // CHECK  | run validator on staging, register the result code
  // COMMIT | write staging if code is OK, pulse done with the code

  localparam logic [SESS_W:0] SESS_LIMIT = NUM_SESS[SESS_W:0];

  cfg_state_e          state, stateNext;
  fix_cfg_t            stageCfg;
  logic [SESS_W:0]     stageSess;
  logic [2:0]          chkCode, codeQ;
  fix_cfg_t            store [NUM_SESS];
  logic [NUM_SESS-1:0] sessValid;
  logic                commitOk;
  logic [SESS_W-1:0]   rdIdx;

  fix_cfg_check #(.NUM_SESS(NUM_SESS)) uCheck (
    .cfg     (stageCfg),
    .sess    (stageSess),
    .errCode (chkCode)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext      = state;
    cfg_ready_o    = 1'b0;
    cfg_done_o     = 1'b0;
    cfg_err_code_o = CFG_OK;
    case (state)
      IDLE: begin
        cfg_ready_o = !rst;
        if (cfg_valid_i) stateNext = CHECK;
      end
      CHECK: stateNext = COMMIT;
      COMMIT: begin
        // a reset landing on the commit cycle aborts the write entirely
        cfg_done_o     = !rst;
        cfg_err_code_o = rst ? CFG_OK : codeQ;
        stateNext      = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stageCfg  <= '0;
      stageSess <= '0;
      codeQ     <= CFG_OK;
    end else begin
      if ((state == IDLE) && cfg_valid_i) begin
        stageCfg  <= cfg_i;
        stageSess <= cfg_sess_i;
      end
      if (state == CHECK) codeQ <= chkCode;
    end
  end

  assign commitOk = (state == COMMIT) && (codeQ == CFG_OK) && !rst;

  // commit is written after invalidate so it wins on a same-session collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SESS; i++) store[i] <= '0;
      sessValid <= '0;
    end else begin
      if (inv_i && (int'(inv_sess_i) < NUM_SESS)) begin
        store[inv_sess_i]     <= '0;
        sessValid[inv_sess_i] <= 1'b0;
      end
      if (commitOk) begin
        store[stageSess[SESS_W-1:0]]     <= stageCfg;
        sessValid[stageSess[SESS_W-1:0]] <= 1'b1;
      end
    end
  end

  assign sess_valid_o = sessValid;
  assign rdIdx        = rd_sess_i[SESS_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cfg_o   <= '0;
      rd_valid_o <= 1'b0;
    end else if (rd_sess_i < SESS_LIMIT) begin
      rd_cfg_o   <= store[rdIdx];
      rd_valid_o <= sessValid[rdIdx];
    end else begin
      rd_cfg_o   <= '0;
      rd_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fix_session_config.sv
// Scoreboard bench for fix_session_config: directed scenarios then randomized
// writes, invalidates and reads checked against a table-level reference model.
module tb_fix_session_config;
  import fix_cfg_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [2:0] cfg_sess_i;
  fix_cfg_t   cfg_i;
  logic       cfg_done_o;
  logic [2:0] cfg_err_code_o;
  logic       inv_i;
  logic [1:0] inv_sess_i;
  logic [2:0] rd_sess_i;
  fix_cfg_t   rd_cfg_o;
  logic       rd_valid_o;
  logic [3:0] sess_valid_o;

  fix_session_config #(.NUM_SESS(4)) dut (
    .clk(clk), .rst(rst), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_sess_i(cfg_sess_i), .cfg_i(cfg_i), .cfg_done_o(cfg_done_o),
    .cfg_err_code_o(cfg_err_code_o), .inv_i(inv_i), .inv_sess_i(inv_sess_i),
    .rd_sess_i(rd_sess_i), .rd_cfg_o(rd_cfg_o), .rd_valid_o(rd_valid_o),
    .sess_valid_o(sess_valid_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nVec = 0;
  int nErr = 0;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: expected table contents and pending write results
  typedef struct {
    int       sess;
    fix_cfg_t cfg;
    logic [2:0] code;
    int       due;
  } exp_t;

  exp_t       expQ[$];
  fix_cfg_t   expStore [4];
  logic [3:0] expValid   = '0;
  fix_cfg_t   expRdCfg   = '0;
  logic       expRdValid = 1'b0;
  exp_t       monE;
  bit         monCommit;

  function automatic logic [2:0] refCode(input int s, input fix_cfg_t c);
    if (s >= 4) return 3'd1;
    if (c.heartbeat_int == 0) return 3'd2;
    if (c.start_time >= c.end_time && !(c.start_time == 0 && c.end_time == 0)) return 3'd3;
    if (c.connect_type == 2'b11) return 3'd4;
    if (c.sender_comp_id == c.target_comp_id) return 3'd5;
    return 3'd0;
  endfunction

  function automatic fix_cfg_t mkCfg(input logic [7:0] hb, input logic [15:0] st,
                                     input logic [15:0] en, input logic [1:0] ct, input bit same);
    fix_cfg_t c;
    c.connect_type        = ct;
    c.reconnect_int       = 8'($urandom);
    c.start_time          = st;
    c.end_time            = en;
    c.begin_string        = 6'($urandom);
    c.default_appl_ver_id = 6'($urandom);
    for (int i = 0; i < 8; i++) begin
      c.sender_comp_id[i*32 +: 32] = $urandom;
      c.target_comp_id[i*32 +: 32] = $urandom;
    end
    if (same) c.target_comp_id = c.sender_comp_id;
    c.host_addr     = 16'($urandom);
    c.heartbeat_int = hb;
    return c;
  endfunction

  initial for (int i = 0; i < 4; i++) expStore[i] = '0;

  // monitor: compares outputs every cycle and advances the model one edge
  always @(negedge clk) begin
    chk("sess_valid", sess_valid_o, expValid);
    chk("rd_valid", rd_valid_o, expRdValid);
    chk("rd_cfg", rd_cfg_o, expRdCfg);
    if (rst) begin
      chk("ready_in_rst", cfg_ready_o, 0);
      chk("done_in_rst", cfg_done_o, 0);
      expQ.delete();
      expValid = '0;
      for (int i = 0; i < 4; i++) expStore[i] = '0;
      expRdCfg   = '0;
      expRdValid = 1'b0;
    end else begin
      monCommit = 1'b0;
      if (cfg_done_o) begin
        if (expQ.size() == 0) chk("spurious_done", cfg_done_o, 0);
        else begin
          monE = expQ.pop_front();
          chk("done_cycle", cyc, monE.due);
          chk("err_code", cfg_err_code_o, monE.code);
          monCommit = (monE.code == 3'd0);
        end
      end else if (expQ.size() != 0 && expQ[0].due <= cyc) begin
        chk("missing_done", cfg_done_o, 1);
        void'(expQ.pop_front());
      end
      if (rd_sess_i < 4) begin
        expRdCfg   = expStore[rd_sess_i[1:0]];
        expRdValid = expValid[rd_sess_i[1:0]];
      end else begin
        expRdCfg   = '0;
        expRdValid = 1'b0;
      end
      if (inv_i) begin
        expValid[inv_sess_i] = 1'b0;
        expStore[inv_sess_i] = '0;
      end
      if (monCommit) begin
        expValid[monE.sess] = 1'b1;
        expStore[monE.sess] = monE.cfg;
      end
    end
  end

  // issue a write, hold it until accepted; returns #1 after the accepting edge
  task automatic doWrite(input int sess, input fix_cfg_t c, input bit drop, output int accCyc);
    exp_t e;
    int   waitN = 0;
    cfg_valid_i = 1'b1;
    cfg_sess_i  = 3'(sess);
    cfg_i       = c;
    accCyc      = -1;
    while (accCyc < 0) begin
      @(negedge clk);
      if (cfg_ready_o === 1'b1) accCyc = cyc;
      else if (++waitN > 20) begin
        chk("handshake_timeout", cfg_ready_o, 1);
        cfg_valid_i = 1'b0;
        return;
      end
    end
    e.sess = sess; e.cfg = c; e.code = refCode(sess, c); e.due = accCyc + 2;
    expQ.push_back(e);
    @(posedge clk); #1;
    if (drop) cfg_valid_i = 1'b0;
  endtask

  task automatic writeCheck(input int sess, input fix_cfg_t c, input logic [2:0] code);
    int acc;
    doWrite(sess, c, 1'b1, acc);
    @(posedge clk);
    @(negedge clk);
    chk("done_at_n2", cfg_done_o, 1);
    chk("code_at_n2", cfg_err_code_o, code);
    @(posedge clk); #1;
  endtask

  bit randBg = 1'b0;
  always @(posedge clk) begin
    #1;
    if (randBg) begin
      inv_i      = ($urandom_range(0, 5) == 0);
      inv_sess_i = 2'($urandom_range(0, 3));
      rd_sess_i  = 3'($urandom_range(0, 7));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr + 1);
    $fatal(1, "watchdog");
  end

  int          tSess [6] = '{5, 0, 0, 0, 0, 3};
  logic [7:0]  tHb   [6] = '{0, 0, 10, 10, 10, 10};
  logic [15:0] tSt   [6] = '{1, 5, 16'h0300, 1, 1, 0};
  logic [15:0] tEn   [6] = '{2, 3, 16'h0300, 2, 2, 0};
  logic [1:0]  tCt   [6] = '{1, 1, 1, 3, 0, 1};
  bit          tSame [6] = '{0, 0, 0, 0, 1, 0};
  logic [2:0]  tCode [6] = '{1, 2, 3, 4, 5, 0};
  logic [3:0]  tVal  [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1010};

  initial begin
    fix_cfg_t rec, recB, recC;
    int a0, a1, a2, s;
    bit drop;
    rst = 1'b1; cfg_valid_i = 1'b0; cfg_sess_i = '0; cfg_i = '0;
    inv_i = 1'b0; inv_sess_i = '0; rd_sess_i = 3'd2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cfg_ready_o, 1);
    chk("done_idle", cfg_done_o, 0);
    chk("valid_idle", sess_valid_o, 4'b0000);
    chk("rd2_idle", {rd_valid_o, rd_cfg_o}, 0);
    @(posedge clk); #1;

    rec = mkCfg(8'd30, 16'h0100, 16'h0200, 2'd1, 1'b0);
    writeCheck(1, rec, 3'd0);
    rd_sess_i = 3'd1;
    @(negedge clk);
    chk("valid_after_w1", sess_valid_o, 4'b0010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd1_valid", rd_valid_o, 1);
    chk("rd1_cfg", rd_cfg_o, rec);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      writeCheck(tSess[i], mkCfg(tHb[i], tSt[i], tEn[i], tCt[i], tSame[i]), tCode[i]);
      @(negedge clk);
      chk("valid_after_prio", sess_valid_o, tVal[i]);
      @(posedge clk); #1;
    end

    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    doWrite(0, mkCfg(8'd1, 16'd1, 16'd9, 2'd0, 1'b0), 1'b0, a0);
    doWrite(1, mkCfg(8'd2, 16'd0, 16'd0, 2'd1, 1'b0), 1'b0, a1);
    doWrite(2, mkCfg(8'd3, 16'd7, 16'd8, 2'd2, 1'b0), 1'b1, a2);
    chk("b2b_gap01", a1 - a0, 3);
    chk("b2b_gap12", a2 - a1, 3);
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    chk("valid_b2b", sess_valid_o, 4'b0111);
    @(posedge clk); #1;

    recB = mkCfg(8'd40, 16'd10, 16'd20, 2'd0, 1'b0);
    doWrite(1, recB, 1'b1, a0);
    @(posedge clk); #1;
    inv_i = 1'b1; inv_sess_i = 2'd1;
    @(posedge clk); #1;
    inv_i = 1'b0; rd_sess_i = 3'd1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("collide_same_valid", sess_valid_o[1], 1);
    chk("collide_same_data", rd_cfg_o, recB);
    @(posedge clk); #1;

    recC = mkCfg(8'd50, 16'd11, 16'd21, 2'd2, 1'b0);
    doWrite(1, recC, 1'b1, a0);
    @(posedge clk); #1;
    inv_i = 1'b1; inv_sess_i = 2'd2;
    @(posedge clk); #1;
    inv_i = 1'b0; rd_sess_i = 3'd2;
    @(posedge clk); #1;
    @(negedge clk);
    chk("collide_diff_valid", sess_valid_o, 4'b0011);
    chk("collide_diff_rd", {rd_valid_o, rd_cfg_o}, 0);
    @(posedge clk); #1;

    rd_sess_i = 3'd3;
    doWrite(3, mkCfg(8'd9, 16'd1, 16'd2, 2'd1, 1'b0), 1'b1, a0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", cfg_ready_o, 1);
    chk("valid_after_abort", sess_valid_o, 4'b0000);
    repeat (4) @(posedge clk);
    #1;

    randBg = 1'b1;
    repeat (200) begin
      s    = $urandom_range(0, 5);
      drop = ($urandom_range(0, 1) == 0);
      rec  = mkCfg(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                   16'($urandom_range(0, 4)), 16'($urandom_range(0, 4)),
                   2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      doWrite(s, rec, drop, a0);
      if (drop) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    cfg_valid_i = 1'b0;
    randBg = 1'b0;
    @(posedge clk); #1;
    inv_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
